// File: rtl/injector.sv
// rtl/injector.sv - local flit injector: queues core flits and slots them into free ejector ports
module injector #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [9:0]              nad,
  input  logic [9:0]              sad,
  input  logic [9:0]              ead,
  input  logic [9:0]              wad,
  input  logic [9:0]              inj_flit,
  input  logic                    inj_valid,
  output logic                    inj_ready,
  output logic [9:0]              nout,
  output logic [9:0]              sout,
  output logic [9:0]              eout,
  output logic [9:0]              wout,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    starve
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LIMIT      = CW'(STARVE_LIMIT);

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] starve_cnt_next;
  logic [9:0]    head;
  logic [3:0]    free;
  logic [3:0]    sel;
  logic          nonempty;
  logic          push;
  logic          pop;

  // Readiness depends only on the registered count, so a pop never frees a slot in the same cycle
  assign inj_ready = (fifo_count != FULL_COUNT);
  assign nonempty  = (fifo_count != '0);
  assign push      = inj_valid && inj_ready;
  assign head      = mem[rd_ptr];
  // bit0 = N, bit1 = S, bit2 = E, bit3 = W
  assign free      = {~wad[9], ~ead[9], ~sad[9], ~nad[9]};
  assign pop       = |sel;

  // Pick the first free port in N, S, E, W order for the current head flit
  always_comb begin
    sel = 4'b0000;
    if (nonempty) begin
      if (free[0])      sel = 4'b0001;
      else if (free[1]) sel = 4'b0010;
      else if (free[2]) sel = 4'b0100;
      else if (free[3]) sel = 4'b1000;
    end
  end

  // Starve counter counts blocked cycles with a waiting head and saturates at the limit
  always_comb begin
    starve_cnt_next = '0;
    if (nonempty && (free == 4'b0000)) begin
      if (starve_cnt == LIMIT) starve_cnt_next = starve_cnt;
      else                     starve_cnt_next = starve_cnt + 1'b1;
    end
  end

  // FIFO storage write; pointers are reset separately so stale entries are harmless
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= inj_flit;
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Starve state register; flag mirrors the saturated counter value
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      starve     <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_next;
      starve     <= (starve_cnt_next == LIMIT);
    end
  end

  // Output ports: pass-through everywhere except the single selected port
  always_ff @(posedge clk) begin
    if (rst) begin
      nout <= '0;
      sout <= '0;
      eout <= '0;
      wout <= '0;
    end else begin
      nout <= sel[0] ? head : nad;
      sout <= sel[1] ? head : sad;
      eout <= sel[2] ? head : ead;
      wout <= sel[3] ? head : wad;
    end
  end

endmodule
